// File: rtl/bichito_motion_sprite.sv
// Bichito player sprite: vertical motion (jump impulse + gravity, clamped to a play band),
// frame animation, and a one-cycle-latency pixel path from a constant multi-frame bitmap ROM.
module bichito_motion_sprite #(
    parameter logic [9:0] BASE_XPOS    = 10'd315,
    parameter logic [9:0] Y_RESET      = 10'd240,
    parameter logic [9:0] Y_MIN        = 10'd0,
    parameter logic [9:0] Y_MAX        = 10'd479,
    parameter int         SPRITE_HSIZE = 8,
    parameter int         SPRITE_VSIZE = 16,
    parameter int         NFRAMES      = 2,
    parameter int         FRAME_TICKS  = 8,
    parameter int         GRAVITY      = 1,
    parameter int         JUMP_VEL     = 6,
    parameter int         VEL_MAX      = 8,
    parameter logic [7:0] FG_COLOR     = 8'hff,
    parameter logic [7:0] BG_COLOR     = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       jump,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       visible,
    output logic [9:0] sprite_y,
    output logic       hit_floor,
    output logic       hit_ceiling
);

    localparam int FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int AW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int XW = (SPRITE_HSIZE > 1) ? $clog2(SPRITE_HSIZE) : 1;
    localparam int YW = (SPRITE_VSIZE > 1) ? $clog2(SPRITE_VSIZE) : 1;
    localparam logic [9:0] Y_TOP_MAX = Y_MAX - 10'(SPRITE_VSIZE) + 10'd1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(NFRAMES - 1);
    localparam logic [AW-1:0] LAST_TICK  = AW'(FRAME_TICKS - 1);

    // Trident bitmap, one byte per row, bit c = column c.
    function automatic logic [7:0] base_row(input int r);
        if (r == 2)
            return 8'h08;
        else if (r >= 3 && r <= 7)
            return 8'h49;
        else if (r == 8)
            return 8'h7f;
        else if (r >= 9 && r <= 15)
            return 8'h08;
        else
            return 8'h00;
    endfunction

    logic [SPRITE_HSIZE-1:0] rom [NFRAMES][SPRITE_VSIZE];

    // Odd frames show the trident lifted by one row.
    generate
        for (genvar gi = 0; gi < NFRAMES; gi++) begin : g_frame
            for (genvar gr = 0; gr < SPRITE_VSIZE; gr++) begin : g_row
                assign rom[gi][gr] = SPRITE_HSIZE'(base_row(gr + (gi % 2)));
            end
        end
    endgenerate

    logic signed [5:0] vel_reg;
    logic              jump_pend_reg;
    logic [AW-1:0]     anim_cnt_reg;
    logic [FW-1:0]     frame_idx_reg;

    // Pixel lookup.
    logic [10:0]   x_ext;
    logic [10:0]   y_ext;
    logic [10:0]   sy_ext;
    logic          in_x;
    logic          in_y;
    logic [XW-1:0] ix;
    logic [YW-1:0] iy;
    logic          pix_next;

    always_comb begin
        x_ext    = {1'b0, x_pos};
        y_ext    = {1'b0, y_pos};
        sy_ext   = {1'b0, sprite_y};
        in_x     = (x_ext >= {1'b0, BASE_XPOS}) &&
                   (x_ext < ({1'b0, BASE_XPOS} + 11'(SPRITE_HSIZE)));
        in_y     = (y_ext >= sy_ext) && (y_ext < (sy_ext + 11'(SPRITE_VSIZE)));
        ix       = x_pos[XW-1:0] - BASE_XPOS[XW-1:0];
        iy       = y_pos[YW-1:0] - sprite_y[YW-1:0];
        pix_next = in_x && in_y && rom[frame_idx_reg][iy][ix];
    end

    // Next-motion computation, consumed only on frame_tick.
    logic signed [7:0]  vel_inc;
    logic signed [5:0]  vel_grav;
    logic signed [5:0]  vel_next;
    logic signed [11:0] y_next;
    logic               below_min;
    logic               above_max;

    always_comb begin
        vel_inc   = $signed({{2{vel_reg[5]}}, vel_reg}) + $signed(8'(GRAVITY));
        vel_grav  = (vel_inc > $signed(8'(VEL_MAX))) ? 6'(VEL_MAX) : vel_inc[5:0];
        vel_next  = (jump_pend_reg || jump) ? 6'(-JUMP_VEL) : vel_grav;
        y_next    = $signed({2'b00, sprite_y}) + $signed({{6{vel_next[5]}}, vel_next});
        below_min = y_next < $signed({2'b00, Y_MIN});
        above_max = y_next > $signed({2'b00, Y_TOP_MAX});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite_y      <= Y_RESET;
            vel_reg       <= '0;
            jump_pend_reg <= 1'b0;
            anim_cnt_reg  <= '0;
            frame_idx_reg <= '0;
            hit_floor     <= 1'b0;
            hit_ceiling   <= 1'b0;
            visible       <= 1'b0;
            R             <= BG_COLOR;
            G             <= BG_COLOR;
            B             <= BG_COLOR;
        end else begin
            hit_floor   <= 1'b0;
            hit_ceiling <= 1'b0;
            visible     <= pix_next;
            R           <= pix_next ? FG_COLOR : BG_COLOR;
            G           <= pix_next ? FG_COLOR : BG_COLOR;
            B           <= pix_next ? FG_COLOR : BG_COLOR;

            if (frame_tick) begin
                jump_pend_reg <= 1'b0;
                if (below_min) begin
                    sprite_y    <= Y_MIN;
                    vel_reg     <= '0;
                    hit_ceiling <= 1'b1;
                end else if (above_max) begin
                    sprite_y  <= Y_TOP_MAX;
                    vel_reg   <= '0;
                    hit_floor <= 1'b1;
                end else begin
                    sprite_y <= y_next[9:0];
                    vel_reg  <= vel_next;
                end

                if (anim_cnt_reg == LAST_TICK) begin
                    anim_cnt_reg  <= '0;
                    frame_idx_reg <= (frame_idx_reg == LAST_FRAME) ? '0 : frame_idx_reg + 1'b1;
                end else begin
                    anim_cnt_reg <= anim_cnt_reg + 1'b1;
                end
            end else if (jump) begin
                jump_pend_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bichito_motion_sprite.sv
// Bench for bichito_motion_sprite: fixed vector table, corner-case sequences and a random
// run checked against an integer model of the motion, animation and bitmap rules.
module tb_bichito_motion_sprite;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       jump = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [7:0] R, G, B;
    logic       visible;
    logic [9:0] sprite_y;
    logic       hit_floor, hit_ceiling;

    bichito_motion_sprite dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .jump(jump),
        .x_pos(x_pos), .y_pos(y_pos), .R(R), .G(G), .B(B),
        .visible(visible), .sprite_y(sprite_y),
        .hit_floor(hit_floor), .hit_ceiling(hit_ceiling)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_y, m_vel, m_pend, m_anim, m_frame, m_vis, m_hf, m_hc;

    typedef struct {
        int rst_first;
        int ft;
        int jp;
        int x;
        int y;
        int e_vis;
        int e_sy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Trident drawing rules; frame 1 displays each base row one line higher.
    function automatic int pix(input int f, input int r, input int c);
        int b;
        b = r + f;
        if (b == 2) return int'(c == 3);
        if (b >= 3 && b <= 7) return int'(c == 0 || c == 3 || c == 6);
        if (b == 8) return int'(c <= 6);
        if (b >= 9 && b <= 15) return int'(c == 3);
        return 0;
    endfunction

    task automatic model_reset();
        m_y = 240; m_vel = 0; m_pend = 0; m_anim = 0; m_frame = 0;
        m_vis = 0; m_hf = 0; m_hc = 0;
    endtask

    task automatic model_step(input int ft, input int jp, input int x, input int y);
        int vn, yn;
        if (x >= 315 && x < 323 && y >= m_y && y < m_y + 16)
            m_vis = pix(m_frame, y - m_y, x - 315);
        else
            m_vis = 0;
        m_hf = 0;
        m_hc = 0;
        if (ft != 0) begin
            vn = (m_pend != 0 || jp != 0) ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
            yn = m_y + vn;
            if (yn < 0) begin
                m_y = 0; m_vel = 0; m_hc = 1;
            end else if (yn > 464) begin
                m_y = 464; m_vel = 0; m_hf = 1;
            end else begin
                m_y = yn; m_vel = vn;
            end
            m_pend = 0;
            if (m_anim == 7) begin
                m_anim = 0;
                m_frame = (m_frame + 1) % 2;
            end else begin
                m_anim++;
            end
        end else if (jp != 0) begin
            m_pend = 1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".visible"}, int'(visible), m_vis);
        check({tag, ".rgb"}, int'({R, G, B}), (m_vis != 0) ? 24'hffffff : 0);
        check({tag, ".sprite_y"}, int'(sprite_y), m_y);
        check({tag, ".hit_floor"}, int'(hit_floor), m_hf);
        check({tag, ".hit_ceiling"}, int'(hit_ceiling), m_hc);
    endtask

    task automatic step(input int ft, input int jp, input int x, input int y);
        frame_tick = ft[0];
        jump       = jp[0];
        x_pos      = x[9:0];
        y_pos      = y[9:0];
        @(posedge clk);
        #1;
        model_step(ft, jp, x, y);
        $display("cyc ft=%0d jp=%0d x=%0d y=%0d -> vis=%0d sy=%0d hf=%0d hc=%0d",
                 ft, jp, x, y, visible, sprite_y, hit_floor, hit_ceiling);
        check_model("step");
        frame_tick = 1'b0;
        jump       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        jump = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_model("reset");
        rst = 1'b0;
    endtask

    // Reset raised between edges must take effect without waiting for a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        int probe_y;

        // Static scan and gravity vectors after reset.
        for (int x = 314; x <= 323; x++) begin
            v = '{rst_first: (x == 314) ? 1 : 0, ft: 0, jp: 0, x: x, y: 242,
                  e_vis: (x == 318) ? 1 : 0, e_sy: 240};
            tbl.push_back(v);
        end
        tbl.push_back('{rst_first: 0, ft: 1, jp: 0, x: 0, y: 0, e_vis: 0, e_sy: 241});
        tbl.push_back('{rst_first: 0, ft: 1, jp: 0, x: 0, y: 0, e_vis: 0, e_sy: 243});
        tbl.push_back('{rst_first: 0, ft: 1, jp: 0, x: 0, y: 0, e_vis: 0, e_sy: 246});
        // Jump pulse followed by ticks.
        tbl.push_back('{rst_first: 1, ft: 0, jp: 1, x: 0, y: 0, e_vis: 0, e_sy: 240});
        tbl.push_back('{rst_first: 0, ft: 1, jp: 0, x: 0, y: 0, e_vis: 0, e_sy: 234});
        tbl.push_back('{rst_first: 0, ft: 1, jp: 0, x: 0, y: 0, e_vis: 0, e_sy: 229});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_first != 0) do_reset();
            step(tbl[i].ft, tbl[i].jp, tbl[i].x, tbl[i].y);
            check("tbl.visible", int'(visible), tbl[i].e_vis);
            check("tbl.sprite_y", int'(sprite_y), tbl[i].e_sy);
        end

        // Free fall onto the floor clamp.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            step(1, 0, 0, 0);
            step(0, 0, $urandom_range(310, 325), m_y + $urandom_range(0, 17));
        end
        check("floor.sprite_y", int'(sprite_y), 464);
        step(1, 0, 0, 0);
        check("floor.rest_pulse", int'(hit_floor), 1);
        step(0, 0, 0, 0);
        check("floor.pulse_end", int'(hit_floor), 0);

        // Repeated jumps up into the ceiling clamp, jump coinciding with tick.
        do_reset();
        step(1, 0, 0, 0);
        for (int t = 0; t < 41; t++) step(1, 1, 0, 0);
        check("ceil.pulse", int'(hit_ceiling), 1);
        check("ceil.sprite_y", int'(sprite_y), 0);
        step(0, 0, 0, 0);
        check("ceil.pulse_end", int'(hit_ceiling), 0);
        step(1, 0, 0, 0);
        check("ceil.pend_cleared", int'(sprite_y), 1);

        // Animation: frame changes after ticks 8 and 16, probed via the row that differs.
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            step(1, 0, 0, 0);
            if (t == 8 || t == 16) begin
                probe_y = m_y + 1;
                step(0, 0, 318, probe_y);
                check("anim.frame_probe", int'(visible), (t == 8) ? 1 : 0);
            end
        end
        for (int t = 0; t < 5; t++) step(1, 0, 0, 0);
        async_reset();
        check("anim.reset_sprite_y", int'(sprite_y), 240);
        step(0, 0, 318, 241);
        check("anim.reset_frame0", int'(visible), 0);

        // Random run against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int ft, jp, x, y;
            ft = ($urandom_range(0, 2) == 0) ? 1 : 0;
            jp = ($urandom_range(0, 7) == 0) ? 1 : 0;
            x  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(310, 326);
            y  = m_y + $urandom_range(0, 40) - 10;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            if ($urandom_range(0, 799) == 0) async_reset();
            else step(ft, jp, x, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
